// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit common-anode scan controller: rotates one BCD nibble per slot to a
// shared decoder, with a dark guard interval, leading-zero blanking and frame-synchronous value commit.
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] value_in,
    input  logic        value_load,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [3:0]  bcd_out,
    output logic        seg_blank,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_start
);

    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_CYC - 1);
    localparam logic [TW-1:0] SLOT_LAST  = TW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_GUARD,
        ST_DRIVE
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   tick_reg, tick_next;
    logic [1:0]      digit_reg, digit_next;
    logic [15:0]     shadow_reg, shadow_next;
    logic [15:0]     pending_reg, pending_next;
    logic            pend_flag_reg, pend_flag_next;

    logic [3:0]      bcd_next;
    logic [3:0]      an_next;
    logic            seg_blank_next;
    logic            dp_next;
    logic            frame_start_next;

    logic            slot_end;
    logic            frame_edge;
    logic            lit;
    logic [3:0]      suppress;
    logic [3:0]      nibble [4];

    assign slot_end   = (state_reg == ST_DRIVE) && (tick_reg == SLOT_LAST);
    // Frame boundary: leaving digit 3's slot, or starting up from OFF.
    assign frame_edge = enable && ((state_reg == ST_OFF) || (slot_end && (digit_reg == 2'd3)));

    // Slot sequencing
    always_comb begin
        state_next       = state_reg;
        tick_next        = tick_reg + TW'(1);
        digit_next       = digit_reg;
        frame_start_next = 1'b0;
        if (!enable) begin
            state_next = ST_OFF;
            tick_next  = '0;
            digit_next = 2'd0;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    state_next       = ST_GUARD;
                    tick_next        = '0;
                    digit_next       = 2'd0;
                    frame_start_next = 1'b1;
                end
                ST_GUARD: begin
                    if (tick_reg == GUARD_LAST) begin
                        state_next = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (slot_end) begin
                        state_next       = ST_GUARD;
                        tick_next        = '0;
                        digit_next       = digit_reg + 2'd1;
                        frame_start_next = (digit_reg == 2'd3);
                    end
                end
                default: begin
                    state_next = ST_OFF;
                    tick_next  = '0;
                    digit_next = 2'd0;
                end
            endcase
        end
    end

    // A load landing on a boundary (or while dark) goes straight to the shadow.
    always_comb begin
        shadow_next    = shadow_reg;
        pending_next   = pending_reg;
        pend_flag_next = pend_flag_reg;
        if (value_load && (frame_edge || (state_reg == ST_OFF))) begin
            shadow_next    = value_in;
            pend_flag_next = 1'b0;
        end else if (value_load) begin
            pending_next   = value_in;
            pend_flag_next = 1'b1;
        end else if (frame_edge && pend_flag_reg) begin
            shadow_next    = pending_reg;
            pend_flag_next = 1'b0;
        end
    end

    assign suppress[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nibble
            assign nibble[gi] = shadow_next[4*gi +: 4];
        end
        for (gi = 1; gi < 4; gi++) begin : g_lz
            assign suppress[gi] = lz_en && (shadow_next[15:4*gi] == '0);
        end
        for (gi = 0; gi < 4; gi++) begin : g_anode
            assign an_next[gi] = !((state_next == ST_DRIVE) && (digit_next == 2'(gi)) && !suppress[gi]);
        end
    endgenerate

    // Outputs are computed from next-state values so they line up with the state register.
    always_comb begin
        lit            = (state_next == ST_DRIVE) && !suppress[digit_next];
        seg_blank_next = !lit;
        dp_next        = lit ? ~dp_in[digit_next] : 1'b1;
        bcd_next       = (state_next == ST_OFF) ? 4'h0 : nibble[digit_next];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_OFF;
            tick_reg      <= '0;
            digit_reg     <= 2'd0;
            shadow_reg    <= '0;
            pending_reg   <= '0;
            pend_flag_reg <= 1'b0;
            bcd_out       <= 4'h0;
            seg_blank     <= 1'b1;
            an            <= 4'hF;
            dp            <= 1'b1;
            frame_start   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tick_reg      <= tick_next;
            digit_reg     <= digit_next;
            shadow_reg    <= shadow_next;
            pending_reg   <= pending_next;
            pend_flag_reg <= pend_flag_next;
            bcd_out       <= bcd_next;
            seg_blank     <= seg_blank_next;
            an            <= an_next;
            dp            <= dp_next;
            frame_start   <= frame_start_next;
        end
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexing scan controller that shares one BCD-to-seven-segment decoder across a 4-digit common-anode display. Each cycle it presents one digit nibble to the decoder and drives the matching anode, rotating through the digits at a fixed refresh rate. It inserts a dark guard interval at every digit switch to prevent ghosting, and applies leading-zero suppression. New values are committed only at frame boundaries so the display never shows a torn mix of old and new digits. It sits between game/score logic and the decoder + board pins.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; at 100 MHz this gives a 1 kHz digit rate. Legal range 4..2^20.
- GUARD_CYC, 2000: dark cycles at the start of each slot. Legal range 1..REFRESH_DIV-1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scanning on; low forces display dark.
- value_in  in  16  four BCD nibbles; [3:0] is the rightmost digit (digit 0), [15:12] is the leftmost (digit 3).
- value_load  in  1  one-cycle strobe that captures value_in into the pending register.
- dp_in  in  4  per-digit decimal point request, active-high.
- lz_en  in  1  leading-zero suppression enable.
- bcd_out  out  4  nibble to the decoder input.
- seg_blank  out  1  high means downstream forces all segments off.
- an  out  4  anodes, active-low, one-hot-low while lit.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse at the start of digit 0's slot.

## Operation
- Registers: shadow[15:0] (the value being displayed), pending[15:0], pend_flag, digit_idx[1:0], tick counter of width clog2(REFRESH_DIV), and the state.
- All outputs are registered.
- States:
  - OFF: enable low.
  - GUARD: dark portion of the slot.
  - DRIVE: lit portion of the slot.
- Reset (rst=1 at an edge) clears everything:
  - state=OFF, digit_idx=0, tick=0.
  - shadow=0, pending=0, pend_flag=0.
  - an=4'hF, dp=1, bcd_out=0, seg_blank=1, frame_start=0.
- Reset overrides all other inputs, including mid-slot and mid-load.
- OFF → GUARD when enable=1: digit_idx=0, tick=0, frame_start pulses.
- Any state → OFF when enable=0, at the same edge. In that edge: an=F, seg_blank=1, digit_idx=0, tick=0.
- GUARD:
  - an=4'hF, seg_blank=1, dp=1.
  - bcd_out already equals shadow nibble[digit_idx].
  - After GUARD_CYC cycles → DRIVE.
- DRIVE:
  - an[digit_idx]=0 unless the digit is suppressed.
  - seg_blank=suppressed.
  - dp=~dp_in[digit_idx] unless suppressed (then 1).
  - After REFRESH_DIV−GUARD_CYC cycles: digit_idx increments, wrapping 3→0, then → GUARD.
  - Wrap to 0 pulses frame_start.
- Suppression, when lz_en=1: digit i (i=3,2,1) is suppressed iff the nibbles i..3 of shadow are all zero. Digit 0 is never suppressed. When lz_en=0, nothing is suppressed.
- Nibbles above 9 pass to bcd_out unchanged.
- Load and commit:
  - value_load sets pending=value_in and pend_flag=1.
  - At the frame-boundary edge (3→0 wrap, or OFF→GUARD), if pend_flag: shadow=pending, pend_flag=0.
  - While in OFF, a load also commits immediately.
  - Load on the boundary edge itself: value_in commits directly to shadow, bypassing pending, and pend_flag clears.
  - Back-to-back loads within a frame: the last one wins.

## Timing
- Slot length is exactly REFRESH_DIV cycles; a frame is 4·REFRESH_DIV cycles.
- Per-digit lit time is REFRESH_DIV−GUARD_CYC cycles; duty ≈ ¼.
- frame_start asserts for the first cycle of each digit-0 GUARD.
- Commit latency after value_load: ≤ 4·REFRESH_DIV cycles to the next frame_start. The new shadow is visible on bcd_out starting at that frame_start cycle.
- First edge with rst=0 and enable=1: GUARD for digit 0, frame_start=1.
- an never has two bits low in the same cycle. Every change of the lit anode is separated by ≥ GUARD_CYC cycles of an=4'hF.

## Test plan
All scenarios use REFRESH_DIV=8, GUARD_CYC=2.

- Reset, then enable=1, load 16'h1234: once committed, the sequence repeats every 32 cycles. Per digit it is 2 dark cycles, then 6 cycles with:
  - an=E, bcd_out=4;
  - an=D, bcd_out=3;
  - an=B, bcd_out=2;
  - an=7, bcd_out=1.
  - frame_start pulses every 32 cycles.
- lz_en=1, value 16'h0050: digits 3 and 2 show an=F and seg_blank=1 during DRIVE. Digit 1 shows bcd 5; digit 0 shows bcd 0, lit. With value 16'h0000, only digit 0 is lit.
- Load 16'h9999 during digit-1 DRIVE while showing 16'h1234: remaining digits still show 1234 and 9999 first appears at the next frame_start. Two loads in one frame (16'h1111 then 16'h2222) display 2222.
- Load on the exact 3→0 wrap edge with value 16'h4321: digit 0 of the new frame shows bcd 1.
- dp_in=4'b0100: dp=0 only during digit-2 DRIVE cycles and stays 1 during GUARD.
- enable dropped mid-DRIVE of digit 2: the next cycle has an=F and seg_blank=1. Re-enable restarts at digit 0 with frame_start. rst asserted mid-slot restores all reset values on the next edge.
